// File: rtl/sonar_pkg.sv
// sonar_pkg: shared widths, FSM state encoding and input clamp helper for the sonar blocks
package sonar_pkg;
  localparam int DIST_W = 9;
  localparam int N_SENSORS = 6;
  localparam int HIST_DEPTH = 4;
  localparam int SUM_W = 11;
  typedef logic [DIST_W-1:0] dist_t;
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, PUBLISH} sonar_state_t;
  function automatic dist_t clamp_dist(input dist_t d, input dist_t max_cm);
    return (d == '0 || d > max_cm) ? max_cm : d;
  endfunction
endpackage

// File: rtl/sonar_sample_tick.sv
// sonar_sample_tick: free-running 0..PERIOD-1 counter; clk/rst in, one-cycle tick out on the last count
module sonar_sample_tick #(
  parameter int PERIOD = 3000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(PERIOD);
  logic [CW-1:0] count;
  assign tick = count == CW'(PERIOD - 1);
  always_ff @(posedge clk)
    if (rst || tick) count <= '0;
    else count <= count + 1'b1;
endmodule

// File: rtl/sonar_obstacle_filter.sv
// sonar_obstacle_filter: snapshots Dist1..6 per tick, outputs 4-sample averages (AvgBus), hysteretic Near flags, MinDist/MinIdx and a Valid pulse
module sonar_obstacle_filter
  import sonar_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 3000000,
  parameter int MAX_CM = 400,
  parameter int NEAR_CM = 30,
  parameter int CLEAR_CM = 40
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [DIST_W-1:0]             Dist1,
  input  logic [DIST_W-1:0]             Dist2,
  input  logic [DIST_W-1:0]             Dist3,
  input  logic [DIST_W-1:0]             Dist4,
  input  logic [DIST_W-1:0]             Dist5,
  input  logic [DIST_W-1:0]             Dist6,
  output logic [DIST_W*N_SENSORS-1:0]   AvgBus,
  output logic [N_SENSORS-1:0]          Near,
  output logic [DIST_W-1:0]             MinDist,
  output logic [2:0]                    MinIdx,
  output logic                          Valid
);
  localparam dist_t MAX_D = dist_t'(MAX_CM);
  localparam dist_t NEAR_D = dist_t'(NEAR_CM);
  localparam dist_t CLEAR_D = dist_t'(CLEAR_CM);
  sonar_state_t state, state_n;
  logic tick;
  dist_t din [N_SENSORS];
  dist_t snap [N_SENSORS];
  dist_t hist [N_SENSORS][HIST_DEPTH];
  dist_t avg_w [N_SENSORS];
  logic [N_SENSORS-1:0] flag_w;
  logic [2:0] ch;
  logic [SUM_W-1:0] sum;
  logic [DIST_W:0] scan_min;
  logic [2:0] scan_idx;
  dist_t avg_c;
  logic flag_c, take_min, last;
  logic [DIST_W*N_SENSORS-1:0] avg_bus_n;
  logic [N_SENSORS-1:0] near_n;
  sonar_sample_tick #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk (CLOCK_50),
    .rst (reset),
    .tick(tick)
  );
  assign din = '{Dist1, Dist2, Dist3, Dist4, Dist5, Dist6};
  assign avg_c = sum[SUM_W-1:2];
  assign flag_c = avg_c < NEAR_D ? 1'b1 : avg_c >= CLEAR_D ? 1'b0 : flag_w[ch];
  // scan_min is one bit wider so its MAX_CM+1 start value never wraps
  assign take_min = {1'b0, avg_c} < scan_min;
  assign last = ch == 3'(N_SENSORS - 1);
  // The last channel's result is forwarded so outputs and Valid appear together in PUBLISH
  always_comb begin
    avg_bus_n = '0;
    near_n = flag_w;
    near_n[ch] = flag_c;
    for (int i = 0; i < N_SENSORS; i++)
      avg_bus_n[i*DIST_W +: DIST_W] = 3'(i) == ch ? avg_c : avg_w[i];
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = tick ? CAPTURE : IDLE;
      CAPTURE: state_n = SHIFT;
      SHIFT:   state_n = UPDATE;
      UPDATE:  state_n = last ? PUBLISH : SHIFT;
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      sum <= '0;
      scan_min <= {1'b0, MAX_D} + 1'b1;
      scan_idx <= '0;
      flag_w <= '0;
      Valid <= 1'b0;
      Near <= '0;
      MinDist <= MAX_D;
      MinIdx <= '0;
      AvgBus <= {N_SENSORS{MAX_D}};
      for (int i = 0; i < N_SENSORS; i++) begin
        snap[i] <= MAX_D;
        avg_w[i] <= MAX_D;
        for (int j = 0; j < HIST_DEPTH; j++) hist[i][j] <= MAX_D;
      end
    end else begin
      state <= state_n;
      Valid <= state == UPDATE && last;
      if (state == CAPTURE) begin
        for (int i = 0; i < N_SENSORS; i++) snap[i] <= clamp_dist(din[i], MAX_D);
        ch <= '0;
        scan_min <= {1'b0, MAX_D} + 1'b1;
      end
      if (state == SHIFT) begin
        hist[ch][0] <= snap[ch];
        for (int j = 1; j < HIST_DEPTH; j++) hist[ch][j] <= hist[ch][j-1];
        sum <= SUM_W'(snap[ch]) + SUM_W'(hist[ch][0]) + SUM_W'(hist[ch][1]) + SUM_W'(hist[ch][2]);
      end
      if (state == UPDATE) begin
        avg_w[ch] <= avg_c;
        flag_w[ch] <= flag_c;
        if (take_min) begin
          scan_min <= {1'b0, avg_c};
          scan_idx <= ch;
        end
        ch <= last ? '0 : ch + 1'b1;
        if (last) begin
          AvgBus <= avg_bus_n;
          Near <= near_n;
          MinDist <= take_min ? avg_c : scan_min[DIST_W-1:0];
          MinIdx <= take_min ? ch : scan_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_sonar_obstacle_filter.sv
// tb_sonar_obstacle_filter: directed checks of averaging, hysteresis, clamping, min select and reset abort
module tb_sonar_obstacle_filter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] d1, d2, d3, d4, d5, d6;
  logic [53:0] avg_bus;
  logic [5:0] near;
  logic [8:0] min_dist;
  logic [2:0] min_idx;
  logic valid;
  int checks = 0;
  int errors = 0;
  int n;
  sonar_obstacle_filter #(.SAMPLE_PERIOD(64)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .Dist1   (d1),
    .Dist2   (d2),
    .Dist3   (d3),
    .Dist4   (d4),
    .Dist5   (d5),
    .Dist6   (d6),
    .AvgBus  (avg_bus),
    .Near    (near),
    .MinDist (min_dist),
    .MinIdx  (min_idx),
    .Valid   (valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [53:0] bus(input int a1, a2, a3, a4, a5, a6);
    return {9'(a6), 9'(a5), 9'(a4), 9'(a3), 9'(a2), 9'(a1)};
  endfunction
  task automatic set_d(input int a1, a2, a3, a4, a5, a6);
    d1 = 9'(a1); d2 = 9'(a2); d3 = 9'(a3); d4 = 9'(a4); d5 = 9'(a5); d6 = 9'(a6);
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!valid && cnt < 200);
  endtask
  task automatic scan(input string tag, input int lat, input logic [53:0] eb, input logic [5:0] en, input int emin, input int eidx);
    wait_valid(n);
    check({tag, " latency"}, n, lat);
    check({tag, " avg"}, avg_bus, eb);
    check({tag, " near"}, near, en);
    check({tag, " min"}, min_dist, emin);
    check({tag, " idx"}, min_idx, eidx);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, " avg"}, avg_bus, bus(400, 400, 400, 400, 400, 400));
    check({tag, " near"}, near, 6'd0);
    check({tag, " min"}, min_dist, 400);
    check({tag, " idx"}, min_idx, 0);
    check({tag, " valid"}, valid, 1'b0);
  endtask
  initial begin
    set_d(100, 100, 100, 100, 100, 100);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;
    scan("all100 s1", 77, bus(325, 325, 325, 325, 325, 325), 6'd0, 325, 0);
    @(posedge clk);
    #1;
    check("pulse width", valid, 1'b0);
    scan("all100 s2", 63, bus(250, 250, 250, 250, 250, 250), 6'd0, 250, 0);
    scan("all100 s3", 64, bus(175, 175, 175, 175, 175, 175), 6'd0, 175, 0);
    scan("all100 s4", 64, bus(100, 100, 100, 100, 100, 100), 6'd0, 100, 0);
    set_d(400, 400, 20, 400, 400, 400);
    do_reset();
    scan("near20 s1", 77, bus(400, 400, 305, 400, 400, 400), 6'd0, 305, 2);
    scan("near20 s2", 64, bus(400, 400, 210, 400, 400, 400), 6'd0, 210, 2);
    scan("near20 s3", 64, bus(400, 400, 115, 400, 400, 400), 6'd0, 115, 2);
    scan("near20 s4", 64, bus(400, 400, 20, 400, 400, 400), 6'b000100, 20, 2);
    set_d(400, 400, 35, 400, 400, 400);
    scan("hold35 s1", 64, bus(400, 400, 23, 400, 400, 400), 6'b000100, 23, 2);
    scan("hold35 s2", 64, bus(400, 400, 27, 400, 400, 400), 6'b000100, 27, 2);
    scan("hold35 s3", 64, bus(400, 400, 31, 400, 400, 400), 6'b000100, 31, 2);
    scan("hold35 s4", 64, bus(400, 400, 35, 400, 400, 400), 6'b000100, 35, 2);
    set_d(400, 400, 45, 400, 400, 400);
    scan("clear45 s1", 64, bus(400, 400, 37, 400, 400, 400), 6'b000100, 37, 2);
    scan("clear45 s2", 64, bus(400, 400, 40, 400, 400, 400), 6'd0, 40, 2);
    set_d(0, 511, 401, 400, 400, 400);
    do_reset();
    scan("clamp", 77, bus(400, 400, 400, 400, 400, 400), 6'd0, 400, 0);
    set_d(200, 50, 200, 200, 50, 200);
    scan("min s1", 64, bus(350, 312, 350, 350, 312, 350), 6'd0, 312, 1);
    scan("min s2", 64, bus(300, 225, 300, 300, 225, 300), 6'd0, 225, 1);
    scan("min s3", 64, bus(250, 137, 250, 250, 137, 250), 6'd0, 137, 1);
    scan("min s4", 64, bus(200, 50, 200, 200, 50, 200), 6'd0, 50, 1);
    repeat (55) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b0;
    scan("after abort", 77, bus(350, 312, 350, 350, 312, 350), 6'd0, 312, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
